// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit writing HI/LO
module ex_muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs_data_i,
  input  logic [XLEN-1:0] rt_data_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            div_zero_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dz_q, dz_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              div_q, div_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   raw_q, raw_d;
  logic [2*XLEN-1:0] acc_q, acc_d;

  // Operand preparation: signed ops (op_i[0]==0) work on magnitudes.
  logic            op_signed;
  logic            rs_neg, rt_neg;
  logic [XLEN-1:0] rs_mag, rt_mag;

  // Iteration datapath for one shift-add or restoring-divide step.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] div_next;

  // Final sign correction inputs.
  logic [XLEN-1:0]   fin_quot, fin_rem;
  logic [2*XLEN-1:0] fin_prod;

  // Operand magnitudes and signs from the forwarded rs/rt values.
  always_comb begin
    op_signed = ~op_i[0];
    rs_neg    = op_signed & rs_data_i[XLEN-1];
    rt_neg    = op_signed & rt_data_i[XLEN-1];
    rs_mag    = rs_neg ? -rs_data_i : rs_data_i;
    rt_mag    = rt_neg ? -rt_data_i : rt_data_i;
  end

  // Single iteration step: multiply adds the multiplicand into the upper half
  // then shifts right; divide shifts left and subtracts when the divisor fits.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                (acc_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_ge    = (div_shift >= {1'b0, b_q});
    div_diff  = div_shift[XLEN-1:0] - b_q;
    div_rem   = div_ge ? div_diff : div_shift[XLEN-1:0];
    div_next  = {div_rem, acc_q[XLEN-2:0], div_ge};
  end

  // Sign-corrected results written to HI/LO on the FIN edge.
  always_comb begin
    fin_quot = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    fin_rem  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    fin_prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
  end

  // Next-state and datapath control; everything holds unless a state acts.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    a_d     = a_q;
    b_d     = b_q;
    raw_d   = raw_q;
    acc_d   = acc_q;

    case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          div_d   = op_i[1];
          sa_d    = rs_neg;
          sb_d    = rt_neg;
          a_d     = rs_mag;
          b_d     = rt_mag;
          raw_d   = rs_data_i;
          acc_d   = op_i[1] ? {{XLEN{1'b0}}, rs_mag} : {{XLEN{1'b0}}, rt_mag};
          cnt_d   = CW'(ITER);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = div_q ? div_next : mul_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        if (!flush_i) begin
          done_d = 1'b1;
          if (div_q && (b_q == '0)) begin
            hi_d = raw_q;
            lo_d = '1;
            dz_d = 1'b1;
          end else if (div_q) begin
            hi_d = fin_rem;
            lo_d = fin_quot;
            dz_d = 1'b0;
          end else begin
            hi_d = fin_prod[2*XLEN-1:XLEN];
            lo_d = fin_prod[XLEN-1:0];
            dz_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      raw_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      raw_q   <= raw_d;
      acc_q   <= acc_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign div_zero_o = dz_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule
